// File: rtl/clock_divider_mc.sv
// Multi-channel integer clock divider; each channel divides i_ref_clk by its own ratio and emits tick/update pulses.
// Latency: ratio sampled at a period boundary (or while bypassed) is active the next cycle; tick/upd are registered.
// Backpressure: none; ratio writes between boundaries are held off until the next boundary.
module clock_divider_mc #(
    parameter int RATIO_WD = 8,
    parameter int NUM_CH   = 2
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst,
    input  logic [NUM_CH-1:0]          i_clk_en,
    input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]          o_div_clk,
    output logic [NUM_CH-1:0]          o_tick,
    output logic [NUM_CH-1:0]          o_ratio_upd
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [RATIO_WD-1:0] new_ratio;
        logic [RATIO_WD-1:0] act_ratio;
        logic [RATIO_WD-1:0] nxt_act;
        logic [RATIO_WD-1:0] half_len;
        logic [RATIO_WD-1:0] last_cnt;
        logic [RATIO_WD-2:0] count;
        logic [RATIO_WD-2:0] nxt_cnt;
        logic                div_clk;
        logic                nxt_div;
        logic                en_q;
        logic                tick_q;
        logic                nxt_tick;
        logic                upd_q;
        logic                nxt_upd;
        logic                bypass;
        logic                at_last;

        assign new_ratio = i_div_ratio[k*RATIO_WD +: RATIO_WD];
        assign bypass    = !i_clk_en[k] || (act_ratio < RATIO_WD'(2));

        // Low phase is floor(N/2) cycles, high phase ceil(N/2); odd ratios stretch the high phase.
        assign half_len  = {1'b0, act_ratio[RATIO_WD-1:1]};
        assign last_cnt  = div_clk ? (half_len + RATIO_WD'(act_ratio[0]) - RATIO_WD'(1))
                                   : (half_len - RATIO_WD'(1));
        assign at_last   = ({1'b0, count} == last_cnt);

        always_comb begin
            nxt_act  = act_ratio;
            nxt_cnt  = count;
            nxt_div  = div_clk;
            nxt_tick = 1'b0;
            nxt_upd  = 1'b0;
            if (!i_clk_en[k]) begin
                // Disable wins over a coincident boundary: no load, no update pulse.
                nxt_cnt = '0;
                nxt_div = 1'b0;
            end else if (bypass || !en_q) begin
                // Bypassed or just enabled: sample every cycle, restart the low phase fresh.
                nxt_act = new_ratio;
                nxt_upd = (new_ratio != act_ratio);
                nxt_cnt = '0;
                nxt_div = 1'b0;
            end else if (at_last) begin
                nxt_cnt  = '0;
                nxt_div  = !div_clk;
                nxt_tick = !div_clk;
                if (div_clk) begin
                    nxt_act = new_ratio;
                    nxt_upd = (new_ratio != act_ratio);
                end
            end else begin
                nxt_cnt = count + 1'b1;
            end
        end

        always_ff @(posedge i_ref_clk or negedge i_rst) begin
            if (!i_rst) begin
                act_ratio <= '0;
                count     <= '0;
                div_clk   <= 1'b0;
                en_q      <= 1'b0;
                tick_q    <= 1'b0;
                upd_q     <= 1'b0;
            end else begin
                act_ratio <= nxt_act;
                count     <= nxt_cnt;
                div_clk   <= nxt_div;
                en_q      <= i_clk_en[k];
                tick_q    <= nxt_tick;
                upd_q     <= nxt_upd;
            end
        end

        assign o_div_clk[k]   = bypass ? i_ref_clk : div_clk;
        assign o_tick[k]      = tick_q;
        assign o_ratio_upd[k] = upd_q;
    end

endmodule
